// File: rtl/delay_pkg.sv
// rtl/delay_pkg.sv - shared state encoding and counter-width helper for delay_timer_mc
package delay_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dly_state_e;

  // One spare bit above the widest product so data * ticks never truncates.
  function automatic int dly_cw(input int dw, input int t);
    return dw + $clog2(t) + 1;
  endfunction

endpackage

// File: rtl/delay_chan.sv
// rtl/delay_chan.sv - one delay channel: start sync/edge, FSM, down-counter, period register
module delay_chan
  import delay_pkg::*;
#(
  parameter int DW = 12,
  parameter int T  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic [DW-1:0] data,
  output logic          flag,
  output logic          expire,
  output logic          busy
);

  localparam int CW = dly_cw(DW, T);
  localparam logic [CW-1:0] T_CW = CW'(T);
  localparam logic [CW-1:0] ONE  = CW'(1);

  dly_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] per_q, per_d;
  logic          mode_q, mode_d;
  logic          flag_q, flag_d;
  logic          expire_q, expire_d;
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          edge_det;
  logic [CW-1:0] n_load;

  assign edge_det = s1_q & ~s2_q;
  assign n_load   = CW'(data) * T_CW;

  always_comb begin
    s1_d     = start;
    s2_d     = s1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    mode_d   = mode_q;
    flag_d   = flag_q;
    expire_d = 1'b0;
    if (stop) begin
      // Stop wins over both a pending load and a due expiry.
      state_d = IDLE;
      flag_d  = 1'b0;
      cnt_d   = '0;
    end else if (edge_det) begin
      cnt_d   = n_load;
      per_d   = n_load;
      mode_d  = mode;
      flag_d  = 1'b0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (cnt_q == '0) begin
            expire_d = 1'b1;
            if (mode_q) begin
              flag_d = ~flag_q;
              cnt_d  = (per_q == '0) ? '0 : per_q - ONE;
            end else begin
              flag_d  = 1'b1;
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      per_q    <= '0;
      mode_q   <= 1'b0;
      flag_q   <= 1'b0;
      expire_q <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      mode_q   <= mode_d;
      flag_q   <= flag_d;
      expire_q <= expire_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
    end
  end

  assign flag   = flag_q;
  assign expire = expire_q;
  assign busy   = (state_q == RUN);

endmodule

// File: rtl/delay_timer_mc.sv
// rtl/delay_timer_mc.sv - multi-channel ms delay timer top; DELAY_SIM_SCALE_EN selects the sim tick rate
module delay_timer_mc
  import delay_pkg::*;
#(
  parameter int CH               = 4,
  parameter int DW               = 12,
  parameter int TICKS_PER_MS     = 32,
  parameter int TICKS_PER_MS_SIM = 2
) (
  input  logic             i_clk_32k,
  input  logic             i_rst_n,
  input  logic [CH-1:0]    i_start,
  input  logic [CH-1:0]    i_stop,
  input  logic [CH-1:0]    i_mode,
  input  logic [CH-1:0]    i_dly_en,
  input  logic [CH*DW-1:0] i_data,
  output logic [CH-1:0]    o_delay_time,
  output logic [CH-1:0]    o_expire,
  output logic [CH-1:0]    o_busy
);

`ifdef DELAY_SIM_SCALE_EN
  localparam int T_EFF = TICKS_PER_MS_SIM;
`else
  localparam int T_EFF = TICKS_PER_MS;
`endif

  logic [CH-1:0] flag;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    delay_chan #(
      .DW (DW),
      .T  (T_EFF)
    ) u_chan (
      .clk    (i_clk_32k),
      .rst_n  (i_rst_n),
      .start  (i_start[c]),
      .stop   (i_stop[c]),
      .mode   (i_mode[c]),
      .data   (i_data[c*DW +: DW]),
      .flag   (flag[c]),
      .expire (o_expire[c]),
      .busy   (o_busy[c])
    );
  end

  assign o_delay_time = i_dly_en & flag;

endmodule

// File: tb/tb_delay_timer_mc.sv
// tb/tb_delay_timer_mc.sv - directed self-checking bench for delay_timer_mc at 2 ticks per ms
module tb_delay_timer_mc;

  localparam int CH = 4;
  localparam int DW = 12;

  logic             clk;
  logic             rst_n;
  logic [CH-1:0]    start;
  logic [CH-1:0]    stop;
  logic [CH-1:0]    mode;
  logic [CH-1:0]    dly_en;
  logic [CH*DW-1:0] data;
  logic [CH-1:0]    delay_time;
  logic [CH-1:0]    expire;
  logic [CH-1:0]    busy;

  int total;
  int bad;

  delay_timer_mc #(
    .CH               (CH),
    .DW               (DW),
    .TICKS_PER_MS     (2),
    .TICKS_PER_MS_SIM (2)
  ) dut (
    .i_clk_32k    (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_stop       (stop),
    .i_mode       (mode),
    .i_dly_en     (dly_en),
    .i_data       (data),
    .o_delay_time (delay_time),
    .o_expire     (expire),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int due [CH];
    logic [CH-1:0] exp_v;
    logic seen;
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    start  = '0;
    stop   = '0;
    mode   = '0;
    dly_en = '1;
    data   = '0;

    step(2);
    chk("rst_expire", 32'(expire), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_delay_time", 32'(delay_time), 32'h0);
    rst_n = 1'b1;
    step(1);

    // ch0 one-shot, 5 ms -> N=10, expiry at k+12
    data[0*DW +: DW] = 12'd5;
    start[0] = 1'b1;
    step(1);
    step(11);
    chk("os_pre_expire", 32'(expire[0]), 32'h0);
    chk("os_pre_busy", 32'(busy[0]), 32'h1);
    step(1);
    chk("os_expire", 32'(expire[0]), 32'h1);
    chk("os_dt", 32'(delay_time[0]), 32'h1);
    chk("os_busy_fall", 32'(busy[0]), 32'h0);
    step(1);
    chk("os_pulse_end", 32'(expire[0]), 32'h0);
    chk("os_dt_hold", 32'(delay_time[0]), 32'h1);
    start[0] = 1'b0;
    stop[0]  = 1'b1;
    step(1);
    stop[0] = 1'b0;
    chk("os_stop_dt", 32'(delay_time[0]), 32'h0);

    // ch1 periodic, 3 ms -> N=6, first at k+8 then every 6
    data[1*DW +: DW] = 12'd3;
    mode[1]  = 1'b1;
    start[1] = 1'b1;
    step(1);
    step(7);
    chk("per_pre", 32'(expire[1]), 32'h0);
    chk("per_busy", 32'(busy[1]), 32'h1);
    step(1);
    chk("per_exp1", 32'(expire[1]), 32'h1);
    chk("per_dt1", 32'(delay_time[1]), 32'h1);
    step(5);
    chk("per_gap", 32'(expire[1]), 32'h0);
    step(1);
    chk("per_exp2", 32'(expire[1]), 32'h1);
    chk("per_dt2", 32'(delay_time[1]), 32'h0);
    step(6);
    chk("per_exp3", 32'(expire[1]), 32'h1);
    chk("per_dt3", 32'(delay_time[1]), 32'h1);
    stop[1] = 1'b1;
    step(1);
    stop[1]  = 1'b0;
    start[1] = 1'b0;
    mode[1]  = 1'b0;
    chk("per_stop_busy", 32'(busy[1]), 32'h0);
    chk("per_stop_dt", 32'(delay_time[1]), 32'h0);

    // ch0 retrigger at j=k+6 -> expiry at j+12 only
    start[0] = 1'b1;
    step(1);
    step(2);
    start[0] = 1'b0;
    step(3);
    start[0] = 1'b1;
    step(1);
    step(6);
    chk("rtg_no_old_exp", 32'(expire[0]), 32'h0);
    chk("rtg_busy", 32'(busy[0]), 32'h1);
    step(5);
    chk("rtg_pre", 32'(expire[0]), 32'h0);
    step(1);
    chk("rtg_exp", 32'(expire[0]), 32'h1);
    start[0] = 1'b0;

    // ch2 stop on the expiry edge (N=4, due at k+6)
    data[2*DW +: DW] = 12'd2;
    start[2] = 1'b1;
    step(1);
    step(5);
    stop[2] = 1'b1;
    step(1);
    chk("stp_no_exp", 32'(expire[2]), 32'h0);
    chk("stp_busy", 32'(busy[2]), 32'h0);
    chk("stp_dt", 32'(delay_time[2]), 32'h0);
    stop[2] = 1'b0;
    step(1);
    chk("stp_after", 32'(expire[2]), 32'h0);
    start[2] = 1'b0;
    step(2);

    // ch2 stop on the load edge -> stays IDLE
    start[2] = 1'b1;
    step(1);
    stop[2] = 1'b1;
    step(1);
    stop[2] = 1'b0;
    step(1);
    chk("edge_stop_busy", 32'(busy[2]), 32'h0);
    step(5);
    chk("edge_stop_idle", 32'({busy[2], expire[2], delay_time[2]}), 32'h0);
    start[2] = 1'b0;

    // ch3 zero delay with output gate closed
    data[3*DW +: DW] = 12'd0;
    dly_en[3] = 1'b0;
    start[3]  = 1'b1;
    step(1);
    step(1);
    chk("z_pre", 32'(expire[3]), 32'h0);
    chk("z_busy", 32'(busy[3]), 32'h1);
    step(1);
    chk("z_exp", 32'(expire[3]), 32'h1);
    chk("z_gated", 32'(delay_time[3]), 32'h0);
    dly_en[3] = 1'b1;
    #1;
    chk("z_ungated", 32'(delay_time[3]), 32'h1);

    // all four channels on one edge
    start = '0;
    step(2);
    data[0*DW +: DW] = 12'd1;
    data[1*DW +: DW] = 12'd4;
    data[2*DW +: DW] = 12'd2;
    data[3*DW +: DW] = 12'd0;
    due[0] = 4;
    due[1] = 10;
    due[2] = 6;
    due[3] = 2;
    start = '1;
    step(1);
    for (int m = 1; m <= 11; m++) begin
      step(1);
      for (int c = 0; c < CH; c++) exp_v[c] = (m == due[c]);
      chk($sformatf("multi_m%0d", m), 32'(expire), 32'(exp_v));
    end
    chk("multi_dt", 32'(delay_time), 32'hf);

    // reset mid-count
    start = '0;
    step(2);
    data[0*DW +: DW] = 12'd5;
    start[0] = 1'b1;
    step(1);
    step(4);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_dt", 32'(delay_time), 32'h0);
    chk("rst_mid_exp", 32'(expire), 32'h0);
    start[0] = 1'b0;
    step(1);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int m = 0; m < 20; m++) begin
      step(1);
      seen = seen | (|expire) | (|busy);
    end
    chk("rst_no_late_exp", 32'(seen), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/delay_timer_mc.md
# delay_timer_mc

Multi-channel programmable millisecond delay timer on the 32 kHz always-on clock; parametrised successor of the single-channel power-sequencing delay. Each channel arms on a rising edge of its start level, counts `i_data` milliseconds, then flags expiry. Channels are independent and each supports one-shot or periodic mode, retrigger and stop. Sits between the sequencing FSMs and the rail-enable/reset-release logic.

## Interface
- `CH`, 4: number of channels.
- `DW`, 12: delay field width per channel, in ms.
- `TICKS_PER_MS`, 32: clocks per ms in silicon builds.
- `TICKS_PER_MS_SIM`, 2: clocks per ms when `DELAY_SIM_SCALE_EN` is defined.
- `i_clk_32k`  in  1  32.768 kHz clock; single clock domain.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  CH  per-channel start level; each rising edge arms or retriggers that channel.
- `i_stop`  in  CH  per-channel synchronous stop; returns the channel to IDLE.
- `i_mode`  in  CH  0 = one-shot, 1 = periodic; sampled at load.
- `i_dly_en`  in  CH  output gate; does not affect counting.
- `i_data`  in  CH*DW  per-channel delay in ms; channel c uses bits [c*DW +: DW].
- `o_delay_time`  out  CH  one-shot: expiry level; periodic: toggles on every expiry; gated by `i_dly_en`.
- `o_expire`  out  CH  one-clock expiry pulse, ungated.
- `o_busy`  out  CH  high while the channel is in RUN.

## Operation
- Per channel: sync flops `s1 <= i_start[c]`, `s2 <= s1`; edge = `s1 & !s2`.
- Effective ticks: T = `TICKS_PER_MS`, or `TICKS_PER_MS_SIM` under the macro. N = `i_data[c]` * T.
- Counter width CW = DW + $clog2(T) + 1. The product is computed at CW bits and never truncates.
- States:
  - IDLE: `o_busy` = 0, flag = 0.
  - RUN: `o_busy` = 1; counter decrements by 1 each clock while nonzero.
  - DONE: one-shot terminal state; flag = 1.
- Load, on edge: counter <= N; period register P <= N; mode latched; flag cleared; state <= RUN. This happens from any state, so an edge in RUN retriggers and discards the old count.
- Expiry, in RUN with counter == 0, on the next clock:
  - `o_expire` pulses for one clock.
  - One-shot: state <= DONE; flag <= 1.
  - Periodic: flag toggles; counter <= P-1, saturating at 0; stays in RUN.
- DONE holds until the next edge or a stop.
- `i_stop` high: state <= IDLE, flag <= 0, counter <= 0. Stop has priority over a simultaneous edge and over a simultaneous expiry; no `o_expire` is generated that cycle.
- `i_data` == 0: expiry occurs one clock after load. A periodic channel with P = 0 expires every clock.
- `i_start` falling edges and a held-high level have no effect.
- `o_delay_time[c]` = `i_dly_en[c]` & flag[c], combinational.
- Reset values: all outputs 0, state IDLE, counters 0, P 0, sync flops 0, flags 0.

## Timing
- Edge k is the first clock edge that samples `i_start` high. Load occurs at edge k+1; `i_data` and `i_mode` must be stable across edges k..k+1.
- One-shot: `o_expire` and flag assert at edge k+N+2.
- Periodic: the first expiry is at k+N+2. Subsequent expiries are max(N,1) clocks apart.
- A retrigger edge at j gives expiry at j+N+2, with N recomputed from the current `i_data`.
- Stop is effective at the edge that samples it high; `o_busy` drops at that edge.
- Reset assertion mid-count clears immediately (asynchronous); no expiry follows.

## Configuration
- `DELAY_SIM_SCALE_EN`:
  - Defined: T = `TICKS_PER_MS_SIM`, so simulations of long delays stay short.
  - Undefined: T = `TICKS_PER_MS`.
  - CW follows T, so the counter shrinks in simulation builds. No other behaviour changes.

## Structure
- Package `delay_pkg`:
  - State enum {IDLE, RUN, DONE}, 2 bits.
  - Function `dly_cw(dw, t)` returning CW.
- Sub-module `delay_chan`: one channel (sync, FSM, counter, period register), generated CH times. The top level only slices buses and gates outputs.

## Test plan
- Sim scale, T = 2; ch0 one-shot, `i_data` = 5; raise `i_start` at edge k -> `o_expire[0]` pulse and `o_delay_time[0]` = 1 at k+12, holding; `o_busy[0]` falls at k+12.
- Ch1 periodic, `i_data` = 3 (N = 6) -> first expire at k+8, then every 6 clocks; `o_delay_time[1]` toggles at each expiry.
- Ch0 running with N = 10; second rising edge at j = k+6 -> no expiry at k+12; expiry at j+12.
- `i_stop` asserted on the same edge an expiry is due -> no `o_expire`, state IDLE, flag 0. Edge and stop together -> channel stays IDLE.
- `i_data` = 0 one-shot -> expiry at k+2. `i_dly_en` = 0 -> `o_delay_time` 0 while `o_expire` still pulses. All four channels started on the same edge with different data -> independent, correct expiries.
- Reset pulsed mid-count -> all outputs 0 immediately; no later expiry until a new start edge.
